// File: rtl/out_vector_pkg.sv
// Shared types and defaults for the output vector sequencer.
package out_vector_pkg;

  localparam int unsigned LANES_DEF = 4;
  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned LANE_W    = $clog2(LANES_DEF);

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter: round-robin with OUT_VECTOR_CTRL_RR_EN, otherwise fixed
// priority with req[0] over req[1]. A non-zero grant is always an accepted request.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef OUT_VECTOR_CTRL_RR_EN
  // Set when req[1] won most recently; reset value lets req[0] win the first tie.
  logic last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (|grant) begin
      last_grant_q <= grant[1];
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    grant = req;
    if (req[0]) begin
      grant = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/out_vector_ctrl.sv
// Arbitrates whole-vector writes into the output vector register, then drains it one
// lane per handshake. Arbitration mode is selected by OUT_VECTOR_CTRL_RR_EN.
module out_vector_ctrl
  import out_vector_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic [LANES*WIDTH-1:0]     req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [LANES*WIDTH-1:0]     req1_data,
  output logic                       req1_ready,
  output logic                       vec_we,
  output logic [LANES*WIDTH-1:0]     vec_d,
  input  logic [LANES*WIDTH-1:0]     vec_q,
  output logic                       drain_valid,
  input  logic                       drain_ready,
  output logic [WIDTH-1:0]           drain_data,
  output logic [$clog2(LANES)-1:0]   drain_lane,
  output logic                       drain_last,
  output logic                       busy
);

  localparam int unsigned LaneW = $clog2(LANES);
  localparam logic [LaneW-1:0] LastLane = LaneW'(LANES - 1);

  state_e           state_q;
  logic [LaneW-1:0] lane_q;
  logic [1:0]       req_idle;
  logic [1:0]       grant;
  logic             in_drain;
  logic             at_last;
  logic [WIDTH-1:0] lane_val [LANES];

  assign in_drain = (state_q == StDrain);
  assign at_last  = (lane_q == LastLane);

  // Requests are only visible to the arbiter in IDLE, so the register is never
  // overwritten while a drain is in progress.
  assign req_idle = {req1_valid, req0_valid} & {2{~in_drain}};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_idle),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lane_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            state_q <= StDrain;
            lane_q  <= '0;
          end
        end
        StDrain: begin
          if (drain_ready) begin
            if (at_last) begin
              state_q <= StIdle;
            end else begin
              lane_q <= lane_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_val[i] = vec_q[i*WIDTH +: WIDTH];
    end
  end

  // Ready and write strobe are forced low while reset is asserted.
  always_comb begin
    req0_ready = grant[0] & rst_n;
    req1_ready = grant[1] & rst_n;
    vec_we     = (|grant) & rst_n;
    vec_d      = grant[1] ? req1_data : req0_data;
  end

  always_comb begin
    drain_valid = in_drain;
    drain_data  = in_drain ? lane_val[lane_q] : '0;
    drain_lane  = in_drain ? lane_q : '0;
    drain_last  = in_drain & at_last;
    busy        = in_drain;
  end

endmodule

// File: tb/tb_out_vector_ctrl.sv
// Scoreboard bench for out_vector_ctrl; expectations follow OUT_VECTOR_CTRL_RR_EN.
module tb_out_vector_ctrl;

  localparam int unsigned LANES = 4;
  localparam int unsigned WIDTH = 32;

  typedef struct {
    int          lane;
    logic [31:0] data;
  } sb_t;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [127:0]     req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             vec_we;
  logic [127:0]     vec_d;
  logic [127:0]     vec_reg;
  logic             drain_valid, drain_ready, drain_last, busy;
  logic [31:0]      drain_data;
  logic [1:0]       drain_lane;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_id;
  int acc_cyc;
  logic m_busy = 1'b0;
  logic m_last = 1'b1;
  sb_t  sb[$];
  int   ids[$];
  int   cycs[$];

  out_vector_ctrl #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .vec_we      (vec_we),
    .vec_d       (vec_d),
    .vec_q       (vec_reg),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready),
    .drain_data  (drain_data),
    .drain_lane  (drain_lane),
    .drain_last  (drain_last),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output vector register (no reset), written by the DUT strobe.
  always @(posedge clk) begin
    if (vec_we) vec_reg <= vec_d;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict and compare outputs, advance the model, step to next negedge.
  task automatic cycle();
    logic [1:0] eg;
    sb_t        e;
    #1;
    cyc++;
    acc_id = -1;
    eg = 2'b00;
    if (!m_busy) begin
      if (req0_valid && req1_valid) begin
`ifdef OUT_VECTOR_CTRL_RR_EN
        eg = m_last ? 2'b01 : 2'b10;
`else
        eg = 2'b01;
`endif
      end else begin
        eg = {req1_valid, req0_valid};
      end
    end
    chk("req0_ready", 128'(req0_ready), 128'(eg[0]));
    chk("req1_ready", 128'(req1_ready), 128'(eg[1]));
    chk("vec_we", 128'(vec_we), 128'(|eg));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("drain_valid", 128'(drain_valid), 128'(m_busy));
    if (m_busy) begin
      chk("sb_nonempty", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) begin
        e = sb[0];
        chk("drain_data", 128'(drain_data), 128'(e.data));
        chk("drain_lane", 128'(drain_lane), 128'(e.lane));
        chk("drain_last", 128'(drain_last), 128'(e.lane == LANES - 1));
        if (drain_ready) begin
          void'(sb.pop_front());
          if (e.lane == LANES - 1) m_busy = 1'b0;
        end
      end
    end else if (|eg) begin
      for (int l = 0; l < LANES; l++) begin
        e.lane = l;
        e.data = eg[1] ? req1_data[l*WIDTH +: WIDTH] : req0_data[l*WIDTH +: WIDTH];
        sb.push_back(e);
      end
      m_busy  = 1'b1;
      m_last  = eg[1];
      acc_id  = eg[1] ? 1 : 0;
      acc_cyc = cyc;
    end
    @(negedge clk);
  endtask

  initial begin
    int t0;
    logic got;
    int exp_ids[3];

    rst_n       = 1'b0;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    req1_data   = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    drain_ready = 1'b1;
    #3;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_drain_valid", 128'(drain_valid), 128'(0));
    chk("rst_vec_we", 128'(vec_we), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Single request from req0 with free-running drain.
    req0_valid = 1'b1;
    cycle();
    req0_valid = 1'b0;
    repeat (6) cycle();
    chk("single_sb_empty", 128'(sb.size()), 128'(0));

    // Backpressure: drain_ready pattern 1,0,0,1,0,0,...
    req1_valid = 1'b1;
    cycle();
    req1_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drain_ready = (i % 3 == 0);
      cycle();
    end
    drain_ready = 1'b1;
    chk("bp_sb_empty", 128'(sb.size()), 128'(0));

    // req1 raised during drain: accepted one cycle after the last-lane handshake.
    req0_data  = {32'h0D, 32'h0C, 32'h0B, 32'h0A};
    req1_data  = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
    req0_valid = 1'b1;
    cycle();
    t0 = acc_cyc;
    req0_valid = 1'b0;
    cycle();
    req1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (acc_id == 1) got = 1'b1;
    end
    req1_valid = 1'b0;
    chk("late_req1_accepted", 128'(got), 128'(1));
    chk("late_req1_latency", 128'(acc_cyc - t0), 128'(LANES + 1));
    repeat (5) cycle();

    // Contention: both valid continuously for three vector slots.
    req0_data  = {32'hC4, 32'hC3, 32'hC2, 32'hC1};
    req1_data  = {32'hD4, 32'hD3, 32'hD2, 32'hD1};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (acc_id >= 0) begin
        ids.push_back(acc_id);
        cycs.push_back(acc_cyc);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (5) cycle();
`ifdef OUT_VECTOR_CTRL_RR_EN
    exp_ids = '{0, 1, 0};
`else
    exp_ids = '{0, 0, 0};
`endif
    chk("cont_count", 128'(ids.size()), 128'(3));
    for (int i = 0; i < 3 && i < ids.size(); i++) begin
      chk("cont_grant", 128'(ids[i]), 128'(exp_ids[i]));
      if (i > 0) chk("cont_interval", 128'(cycs[i] - cycs[i-1]), 128'(LANES + 1));
    end

    // Reset while presenting lane 2.
    req0_data  = {32'hE4, 32'hE3, 32'hE2, 32'hE1};
    req0_valid = 1'b1;
    cycle();
    req0_valid = 1'b0;
    repeat (2) cycle();
    #1;
    chk("pre_rst_lane", 128'(drain_lane), 128'(2));
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", 128'(req0_ready), 128'(0));
    chk("rst_req1_ready", 128'(req1_ready), 128'(0));
    chk("rst_vec_we2", 128'(vec_we), 128'(0));
    chk("rst_drain_valid2", 128'(drain_valid), 128'(0));
    chk("rst_busy2", 128'(busy), 128'(0));
    chk("rst_drain_lane", 128'(drain_lane), 128'(0));
    chk("rst_drain_last", 128'(drain_last), 128'(0));
    sb.delete();
    m_busy = 1'b0;
    m_last = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_hold_valid", 128'(drain_valid), 128'(0));
    @(negedge clk);
    rst_n      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) cycle();

    // First tie after reset goes to req0.
    req0_data  = {32'hF4, 32'hF3, 32'hF2, 32'hF1};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    cycle();
    chk("post_rst_winner", 128'(acc_id), 128'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (5) cycle();
    chk("final_sb_empty", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
